axi4lite_slave_regs: RTL and testbench

AXI4LITE_SLAVE_REGS -- requirements
Module: axi4lite_slave_regs

---
 rtl/axi4lite_slave_regs_if.sv | 34 +++
 rtl/axi4lite_slave_regs.sv | 106 ++++++++++
 tb/tb_axi4lite_slave_regs.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_slave_regs_if.sv
// AXI4-Lite bus bundle for the small register slave.
// Clock and reset stay as plain ports on the modules that use this bundle.
interface axi4lite_slave_regs_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite register slave: 2^ADDR_WIDTH registers, independent AW/W capture, one-cycle reads.
// Define AXIL_WRCNT_EN to turn the top register into a read-only count of OKAY write commits.
module axi4lite_slave_regs #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   axi4lite_slave_regs_if.slave bus
);
   localparam int         NUM_REGS    = 1 << ADDR_WIDTH;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  aw_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic                  w_held;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic                  w_strb_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   logic commit;
   logic wr_reject;
   logic wr_update;

   assign bus.awready = !aw_held;
   assign bus.wready  = !w_held;
   assign bus.arready = !rvalid_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;

   assign aw_hs  = bus.awvalid && !aw_held;
   assign w_hs   = bus.wvalid && !w_held;
   assign ar_hs  = bus.arvalid && !rvalid_q;
   // A pending response blocks the next commit, so bresp can never be overwritten.
   assign commit = aw_held && w_held && !bvalid_q;

`ifdef AXIL_WRCNT_EN
   localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = '1;
   assign wr_reject = (aw_addr_q == CNT_ADDR);
`else
   assign wr_reject = 1'b0;
`endif

   assign wr_update = commit && w_strb_q && !wr_reject;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         aw_held   <= 1'b0;
         aw_addr_q <= '0;
         w_held    <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= bus.awaddr;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
         end

         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_reject ? RESP_SLVERR : RESP_OKAY;
         end else if (bvalid_q && bus.bready) begin
            bvalid_q <= 1'b0;
         end

         if (wr_update) regs[aw_addr_q] <= w_data_q;
`ifdef AXIL_WRCNT_EN
         if (commit && !wr_reject) regs[CNT_ADDR] <= regs[CNT_ADDR] + DATA_WIDTH'(1);
`endif

         // Sampling regs here yields the pre-write value when a commit hits the same edge.
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= regs[bus.araddr];
            rresp_q  <= RESP_OKAY;
         end else if (rvalid_q && bus.rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs; inputs change and outputs are sampled 1ns after posedge.
module tb_axi4lite_slave_regs;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   axi4lite_slave_regs_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

   axi4lite_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Finish an outstanding write response: bvalid must be up with the given resp.
   task automatic take_bresp(input string tag, input logic [1:0] exp_resp);
      check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
      check({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check({tag, "_bvalid_clr"}, 32'(bus.bvalid), 32'd0);
   endtask

   task automatic write_txn(input string tag, input logic [1:0] addr, input logic [7:0] data,
                            input logic strb, input logic [1:0] exp_resp);
      bus.awvalid = 1'b1;
      bus.awaddr  = addr;
      bus.wvalid  = 1'b1;
      bus.wdata   = data;
      bus.wstrb   = strb;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check({tag, "_bvalid_early"}, 32'(bus.bvalid), 32'd0);
      tick();
      take_bresp(tag, exp_resp);
   endtask

   task automatic read_txn(input string tag, input logic [1:0] addr, input logic [7:0] exp);
      bus.arvalid = 1'b1;
      bus.araddr  = addr;
      tick();
      bus.arvalid = 1'b0;
      check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
      check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp));
      check({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      check({tag, "_rvalid_clr"}, 32'(bus.rvalid), 32'd0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.awvalid = 1'b0;
      bus.awaddr  = '0;
      bus.wvalid  = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = 1'b0;
      bus.bready  = 1'b0;
      bus.arvalid = 1'b0;
      bus.araddr  = '0;
      bus.rready  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_awready", 32'(bus.awready), 32'd1);
      check("rst_wready", 32'(bus.wready), 32'd1);
      check("rst_arready", 32'(bus.arready), 32'd1);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_rdata", 32'(bus.rdata), 32'd0);

      // AW and W in the same cycle, then read back
      write_txn("wr2", 2'd2, 8'h04, 1'b1, 2'b00);
      read_txn("rd2", 2'd2, 8'h04);

      // W three cycles ahead of AW, response held off for five cycles
      bus.wvalid = 1'b1;
      bus.wdata  = 8'hA5;
      bus.wstrb  = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      check("w_first_wready", 32'(bus.wready), 32'd0);
      check("w_first_awready", 32'(bus.awready), 32'd1);
      tick();
      tick();
      bus.awvalid = 1'b1;
      bus.awaddr  = 2'd1;
      tick();
      bus.awvalid = 1'b0;
      check("w_first_bvalid_early", 32'(bus.bvalid), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("hold_bvalid", 32'(bus.bvalid), 32'd1);
         check("hold_awready", 32'(bus.awready), 32'd1);
         check("hold_wready", 32'(bus.wready), 32'd1);
         tick();
      end
      take_bresp("w_first", 2'b00);
      tick();
      check("no_second_commit", 32'(bus.bvalid), 32'd0);
      read_txn("rd1", 2'd1, 8'hA5);

      // Strobe low: OKAY, register untouched
      write_txn("strb0", 2'd2, 8'hFF, 1'b0, 2'b00);
      read_txn("rd2_strb0", 2'd2, 8'h04);

      // Read stalled by rready=0 while addr 0 is written
      bus.arvalid = 1'b1;
      bus.araddr  = 2'd0;
      bus.awvalid = 1'b1;
      bus.awaddr  = 2'd0;
      bus.wvalid  = 1'b1;
      bus.wdata   = 8'h55;
      bus.wstrb   = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("stall_rvalid", 32'(bus.rvalid), 32'd1);
         check("stall_rdata", 32'(bus.rdata), 32'h00);
         check("stall_arready", 32'(bus.arready), 32'd0);
         tick();
      end
      take_bresp("stall_wr", 2'b00);
      check("stall_rdata_after_wr", 32'(bus.rdata), 32'h00);
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      check("stall_rvalid_clr", 32'(bus.rvalid), 32'd0);
      check("stall_arready_back", 32'(bus.arready), 32'd1);
      read_txn("rd0", 2'd0, 8'h55);

      // Back-to-back reads: one idle cycle between handshakes
      bus.arvalid = 1'b1;
      bus.araddr  = 2'd1;
      bus.rready  = 1'b1;
      tick();
      check("b2b_rvalid0", 32'(bus.rvalid), 32'd1);
      check("b2b_rdata0", 32'(bus.rdata), 32'hA5);
      bus.araddr = 2'd2;
      tick();
      check("b2b_idle", 32'(bus.rvalid), 32'd0);
      tick();
      check("b2b_rvalid1", 32'(bus.rvalid), 32'd1);
      check("b2b_rdata1", 32'(bus.rdata), 32'h04);
      bus.arvalid = 1'b0;
      tick();
      bus.rready = 1'b0;
      check("b2b_rvalid_clr", 32'(bus.rvalid), 32'd0);

`ifndef AXIL_WRCNT_EN
      // Read and commit to addr 3 on the same edge: old value returned
      bus.awvalid = 1'b1;
      bus.awaddr  = 2'd3;
      bus.wvalid  = 1'b1;
      bus.wdata   = 8'h7E;
      bus.wstrb   = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.arvalid = 1'b1;
      bus.araddr  = 2'd3;
      tick();
      bus.arvalid = 1'b0;
      check("same_edge_rdata", 32'(bus.rdata), 32'h00);
      check("same_edge_rvalid", 32'(bus.rvalid), 32'd1);
      take_bresp("same_edge_wr", 2'b00);
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      read_txn("rd3", 2'd3, 8'h7E);
`endif

      // Reset with a pending response discards it
      bus.awvalid = 1'b1;
      bus.awaddr  = 2'd1;
      bus.wvalid  = 1'b1;
      bus.wdata   = 8'h33;
      bus.wstrb   = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      tick();
      check("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
      rst_n = 1'b0;
      tick();
      check("in_rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("in_rst_awready", 32'(bus.awready), 32'd1);
      rst_n = 1'b1;
      tick();
      tick();
      check("post_rst_bvalid", 32'(bus.bvalid), 32'd0);

      // Reset with captured but uncommitted AW/W
      bus.awvalid = 1'b1;
      bus.awaddr  = 2'd2;
      bus.wvalid  = 1'b1;
      bus.wdata   = 8'h99;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      rst_n       = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("held_rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("held_rst_wready", 32'(bus.wready), 32'd1);
      for (int a = 0; a < 4; a++) read_txn("rst_regs", 2'(a), 8'h00);

`ifdef AXIL_WRCNT_EN
      // Commit counter wraps after 256 writes; writes to it are rejected
      for (int i = 0; i < 256; i++) write_txn("cnt_wr", 2'd0, 8'(i), 1'b1, 2'b00);
      read_txn("cnt_wrapped", 2'd3, 8'h00);
      write_txn("cnt_reject", 2'd3, 8'h5A, 1'b1, 2'b10);
      read_txn("cnt_after_reject", 2'd3, 8'h00);
      write_txn("cnt_one", 2'd1, 8'h11, 1'b1, 2'b00);
      read_txn("cnt_incr", 2'd3, 8'h01);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
